// File: rtl/gemm_ctrl_pkg.sv
// Shared types for the GEMM tile sequencer: controller states and the
// {valid, first} tag that travels alongside the MAC pipeline.
package gemm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        EMIT
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
    } dl_entry_t;

endpackage

// File: rtl/ctrl_delay_line.sv
// PIPE_LAT-deep shift register for the accumulator control tag, synchronously
// cleared on reset; a zero-depth instance is a plain wire.
module ctrl_delay_line
    import gemm_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  dl_entry_t d,
    output dl_entry_t q
);

    generate
        if (PIPE_LAT == 0) begin : g_pass
            assign q = d;
        end else begin : g_pipe
            dl_entry_t [PIPE_LAT-1:0] pipe;

            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int s = 1; s < PIPE_LAT; s++) pipe[s] <= pipe[s-1];
                end
            end

            assign q = pipe[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks C[i][j] in row-major order, issuing K operand address pairs per element
// and steering the accumulator enables through a delay line matched to the MAC.
module gemm_tile_sequencer
    import gemm_ctrl_pkg::*;
#(
    parameter int DIM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int PIPE_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_m,
    input  logic [DIM_WIDTH-1:0]  cfg_n,
    input  logic [DIM_WIDTH-1:0]  cfg_k,
    output logic                  busy,
    output logic                  done,
    output logic                  op_valid,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  acc_en,
    output logic                  acc_clr,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DIM_WIDTH-1:0]  res_row,
    output logic [DIM_WIDTH-1:0]  res_col
);

    localparam int CW = $clog2(PIPE_LAT + 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t                state, state_nxt;
    logic [DIM_WIDTH-1:0]  m_cfg, n_cfg, k_cfg;
    logic [DIM_WIDTH-1:0]  i_idx, j_idx, k_idx;
    logic [ADDR_WIDTH-1:0] a_base, a_cur, b_cur;
    logic [CW-1:0]         drain_cnt;
    logic                  done_r, done_nxt;
    logic                  cfg_ok, k_last, j_last, i_last;
    dl_entry_t             dl_in, dl_out;

    assign cfg_ok = (|cfg_m) && (|cfg_n) && (|cfg_k);
    assign k_last = (k_idx == k_cfg - 1'b1);
    assign j_last = (j_idx == n_cfg - 1'b1);
    assign i_last = (i_idx == m_cfg - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) state_nxt = ISSUE;
                    else        done_nxt  = 1'b1;
                end
            end
            ISSUE: if (k_last) state_nxt = (PIPE_LAT == 0) ? EMIT : DRAIN;
            DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = EMIT;
            EMIT: begin
                if (res_ready) begin
                    if (i_last && j_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses advance by additions only: a by 1 per k and K per row,
    // b by N per k; each element restarts from (a_base, j).
    always_ff @(posedge clk) begin
        if (reset) begin
            m_cfg     <= '0;
            n_cfg     <= '0;
            k_cfg     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            a_base    <= '0;
            a_cur     <= '0;
            b_cur     <= '0;
            drain_cnt <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= done_nxt;
            case (state)
                IDLE: begin
                    if (start && cfg_ok) begin
                        m_cfg  <= cfg_m;
                        n_cfg  <= cfg_n;
                        k_cfg  <= cfg_k;
                        i_idx  <= '0;
                        j_idx  <= '0;
                        k_idx  <= '0;
                        a_base <= '0;
                        a_cur  <= '0;
                        b_cur  <= '0;
                    end
                end
                ISSUE: begin
                    drain_cnt <= '0;
                    if (k_last) begin
                        k_idx <= '0;
                    end else begin
                        k_idx <= k_idx + 1'b1;
                        a_cur <= a_cur + 1'b1;
                        b_cur <= b_cur + ADDR_WIDTH'(n_cfg);
                    end
                end
                DRAIN: drain_cnt <= drain_cnt + 1'b1;
                EMIT: begin
                    if (res_ready) begin
                        if (i_last && j_last) begin
                            i_idx  <= '0;
                            j_idx  <= '0;
                            a_base <= '0;
                            a_cur  <= '0;
                            b_cur  <= '0;
                        end else if (j_last) begin
                            j_idx  <= '0;
                            i_idx  <= i_idx + 1'b1;
                            a_base <= a_base + ADDR_WIDTH'(k_cfg);
                            a_cur  <= a_base + ADDR_WIDTH'(k_cfg);
                            b_cur  <= '0;
                        end else begin
                            j_idx <= j_idx + 1'b1;
                            a_cur <= a_base;
                            b_cur <= ADDR_WIDTH'(j_idx) + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dl_in = '{valid: (state == ISSUE), first: (k_idx == '0)};

    ctrl_delay_line #(.PIPE_LAT(PIPE_LAT)) u_dly (
        .clk   (clk),
        .reset (reset),
        .d     (dl_in),
        .q     (dl_out)
    );

    assign busy      = (state != IDLE);
    assign done      = done_r;
    assign op_valid  = (state == ISSUE);
    assign a_addr    = a_cur;
    assign b_addr    = b_cur;
    assign acc_en    = dl_out.valid;
    assign acc_clr   = dl_out.valid & dl_out.first;
    assign res_valid = (state == EMIT);
    assign res_row   = i_idx;
    assign res_col   = j_idx;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench: stimulus pushes expected ops/results from a plain-arithmetic
// GEMM walk; a negedge monitor pops and compares whatever the DUT presents.
module tb_gemm_tile_sequencer;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start = 1'b0, start0 = 1'b0;
    logic [DW-1:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
    logic          res_ready = 1'b1, res_ready0 = 1'b1;
    logic          busy, done, op_valid, acc_en, acc_clr, res_valid;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] res_row, res_col;
    logic          busy0, done0, op_valid0, acc_en0, acc_clr0, res_valid0;
    logic [AW-1:0] a_addr0, b_addr0;
    logic [DW-1:0] res_row0, res_col0;

    gemm_tile_sequencer #(.DIM_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_LAT(PL)) u_dut (
        .clk(clk), .reset(reset), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .busy(busy), .done(done), .op_valid(op_valid), .a_addr(a_addr), .b_addr(b_addr),
        .acc_en(acc_en), .acc_clr(acc_clr), .res_valid(res_valid), .res_ready(res_ready),
        .res_row(res_row), .res_col(res_col));

    gemm_tile_sequencer #(.DIM_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .busy(busy0), .done(done0), .op_valid(op_valid0), .a_addr(a_addr0), .b_addr(b_addr0),
        .acc_en(acc_en0), .acc_clr(acc_clr0), .res_valid(res_valid0), .res_ready(res_ready0),
        .res_row(res_row0), .res_col(res_col0));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct { int a; int b; int k; bit klast; bit job_first; } op_t;
    typedef struct { int row; int col; bit last; } res_t;
    typedef struct { int c; bit clr; } acc_t;

    op_t  q_op[$];
    res_t q_res[$];
    acc_t q_acc[$];
    int   q_t0[$];
    int   q_done[$];

    op_t  m_op;
    res_t m_res;
    acc_t m_acc;
    int   m_t0, anchor, last_op_cyc, exp_res_cyc;
    bit   prev_v, prev_r;
    int   prev_row, prev_col;

    // Reference: C[i][j] = sum_k A[i*K+k] * B[k*N+j], walked row-major.
    task automatic push_model(input int m, input int n, input int k);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                for (int kk = 0; kk < k; kk++)
                    q_op.push_back('{(i*k + kk) % (1 << AW), (kk*n + j) % (1 << AW), kk,
                                     kk == k-1, (i == 0 && j == 0 && kk == 0)});
                q_res.push_back('{i, j, (i == m-1 && j == n-1)});
            end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            q_op.delete(); q_res.delete(); q_acc.delete(); q_t0.delete(); q_done.delete();
            prev_v = 1'b0; prev_r = 1'b0; exp_res_cyc = -1;
        end else begin
            if (op_valid) begin
                chk(q_op.size() != 0, "op_unexpected", a_addr, -1);
                chk(busy, "busy_on_issue", busy, 1);
                if (q_op.size() != 0) begin
                    m_op = q_op.pop_front();
                    chk(a_addr == m_op.a, "a_addr", a_addr, m_op.a);
                    chk(b_addr == m_op.b, "b_addr", b_addr, m_op.b);
                    if (m_op.k == 0) begin
                        if (m_op.job_first) begin
                            m_t0 = (q_t0.size() != 0) ? q_t0.pop_front() : -100;
                            chk(cyc == m_t0 + 1, "first_issue_time", cyc, m_t0 + 1);
                        end else begin
                            chk(cyc == anchor + 1, "issue_after_handshake", cyc, anchor + 1);
                        end
                    end else begin
                        chk(cyc == last_op_cyc + 1, "issue_contiguous", cyc, last_op_cyc + 1);
                    end
                    last_op_cyc = cyc;
                    q_acc.push_back('{cyc + PL, m_op.k == 0});
                    if (m_op.klast) exp_res_cyc = cyc + PL + 1;
                end
            end
            if (q_acc.size() != 0 && q_acc[0].c == cyc) begin
                m_acc = q_acc.pop_front();
                chk(acc_en, "acc_en", acc_en, 1);
                chk(acc_clr == m_acc.clr, "acc_clr", acc_clr, m_acc.clr);
            end else begin
                chk(!acc_en && !acc_clr, "acc_spurious", {acc_en, acc_clr}, 0);
            end
            if (res_valid && !prev_v)
                chk(cyc == exp_res_cyc, "res_valid_time", cyc, exp_res_cyc);
            if (prev_v && !prev_r) begin
                chk(res_valid, "res_valid_hold", res_valid, 1);
                chk(res_row == prev_row && res_col == prev_col, "res_idx_hold",
                    res_row * 256 + res_col, prev_row * 256 + prev_col);
            end
            if (res_valid && res_ready) begin
                chk(q_res.size() != 0, "res_unexpected", res_row, -1);
                if (q_res.size() != 0) begin
                    m_res = q_res.pop_front();
                    chk(res_row == m_res.row, "res_row", res_row, m_res.row);
                    chk(res_col == m_res.col, "res_col", res_col, m_res.col);
                    anchor = cyc;
                    if (m_res.last) q_done.push_back(cyc + 1);
                end
            end
            if (q_done.size() != 0 && q_done[0] == cyc) begin
                void'(q_done.pop_front());
                chk(done, "done_pulse", done, 1);
                chk(!busy, "idle_at_done", busy, 0);
            end else begin
                chk(!done, "done_spurious", done, 0);
            end
            prev_v = res_valid; prev_r = res_ready;
            prev_row = res_row; prev_col = res_col;
        end
    end

    // rmode: 0 always ready, 1 random ready, 2 five-cycle stall at t0+12..t0+16
    task automatic run_job(input int m, input int n, input int k, input int rmode,
                           input bit noise, output int t0, output int t_done);
        bit zero;
        zero = (m == 0 || n == 0 || k == 0);
        if (!zero) push_model(m, n, k);
        cfg_m = DW'(m); cfg_n = DW'(n); cfg_k = DW'(k);
        start = 1'b1;
        res_ready = 1'b1;
        t0 = cyc;
        if (zero) q_done.push_back(t0 + 1);
        else      q_t0.push_back(t0);
        t_done = -1;
        for (int b = 0; b < 3000; b++) begin
            tick();
            start = 1'b0;
            if (done) begin
                t_done = cyc;
                break;
            end
            case (rmode)
                1:       res_ready = ($urandom_range(0, 2) != 0);
                2:       res_ready = !((cyc - t0 >= 12) && (cyc - t0 <= 16));
                default: res_ready = 1'b1;
            endcase
            if (noise && busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                cfg_m = DW'($urandom_range(0, 7));
                cfg_n = DW'($urandom_range(0, 7));
                cfg_k = DW'($urandom_range(0, 7));
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        chk(t_done >= 0, "job_timeout", t_done, t0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(!busy && !done && !op_valid, {tag, "_ctl"}, {busy, done, op_valid}, 0);
        chk(!acc_en && !acc_clr && !res_valid, {tag, "_acc_res"}, {acc_en, acc_clr, res_valid}, 0);
        chk(a_addr == 0 && b_addr == 0, {tag, "_addr"}, a_addr + b_addr, 0);
        chk(res_row == 0 && res_col == 0, {tag, "_idx"}, res_row + res_col, 0);
    endtask

    initial begin
        int t0, td, m, n, k;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Reference job: 2x3 result, K=4, no backpressure.
        run_job(2, 3, 4, 0, 1'b0, t0, td);
        chk(td == t0 + 43, "done_time_2x3x4", td - t0, 43);
        repeat (2) tick();

        run_job(1, 3, 3, 2, 1'b0, t0, td);
        chk(td == t0 + 24, "done_time_backpressure", td - t0, 24);
        repeat (2) tick();

        run_job(3, 2, 0, 0, 1'b0, t0, td);
        chk(td == t0 + 1, "zero_dim_done_time", td - t0, 1);
        chk(!busy && !op_valid, "zero_dim_idle", {busy, op_valid}, 0);
        repeat (3) tick();

        // Abort while draining element (1,0).
        push_model(2, 1, 2);
        cfg_m = 2; cfg_n = 1; cfg_k = 2;
        start = 1'b1;
        t0 = cyc;
        q_t0.push_back(t0);
        tick();
        start = 1'b0;
        while (cyc < t0 + 8) tick();
        chk(busy && !op_valid && !res_valid, "in_drain_before_reset", {busy, op_valid, res_valid}, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("midjob_reset");
        repeat (6) tick();

        run_job(2, 2, 2, 0, 1'b0, t0, td);
        chk(td == t0 + 21, "restart_done_time", td - t0, 21);
        tick();
        run_job(2, 2, 3, 0, 1'b1, t0, td);
        chk(td == t0 + 25, "start_while_busy_ignored", td - t0, 25);
        tick();

        for (int r = 0; r < 10; r++) begin
            m = $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            k = $urandom_range(1, 5);
            if ($urandom_range(0, 7) == 0) k = 0;
            run_job(m, n, k, 1, ($urandom_range(0, 1) == 1), t0, td);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Zero-latency build: K=M=N=1.
        cfg_m = 1; cfg_n = 1; cfg_k = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk(op_valid0 && acc_en0 && acc_clr0, "pl0_t1_issue_acc", {op_valid0, acc_en0, acc_clr0}, 7);
        chk(a_addr0 == 0 && b_addr0 == 0 && !res_valid0, "pl0_t1_addr", a_addr0 + b_addr0 + res_valid0, 0);
        tick();
        chk(res_valid0 && !op_valid0 && !acc_en0, "pl0_t2_res", {res_valid0, op_valid0, acc_en0}, 4);
        chk(res_row0 == 0 && res_col0 == 0, "pl0_t2_idx", res_row0 + res_col0, 0);
        tick();
        chk(done0 && !busy0 && !res_valid0, "pl0_t3_done", {done0, busy0, res_valid0}, 4);
        tick();
        chk(!done0, "pl0_done_one_cycle", done0, 0);

        repeat (4) tick();
        chk(q_op.size() == 0, "ops_outstanding", q_op.size(), 0);
        chk(q_res.size() == 0, "results_outstanding", q_res.size(), 0);
        chk(q_acc.size() == 0 && q_done.size() == 0, "acc_done_outstanding", q_acc.size() + q_done.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
